// File: rtl/vga_pixel_bus_writer.sv
// -----------------------------------------------------------------------------
// vga_pixel_bus_writer
//
// Bus initiator that fills a rectangle of the 160x120 monochrome frame buffer
// by issuing byte writes to the VGA peripheral's register map
// (row register, column register, pixel data register).
//
// Every row costs one Y write. Every pixel costs an X write followed by a data
// write. The rectangle is clipped to the screen once, when the command is
// accepted. A write state issues its write only in a cycle that follows an
// edge where BUS_GNT was sampled high. Otherwise the state holds with
// BUS_WE=0, so no write is ever skipped or repeated.
//
// Ports:
//   CLK       in   system clock
//   RESET     in   asynchronous active-low reset
//   START     in   one-cycle command strobe, sampled only in IDLE
//   X0, Y0    in   rectangle origin (column 8b, row 7b)
//   WIDTH     in   rectangle width in columns (8b)
//   HEIGHT    in   rectangle height in rows (7b)
//   PIXEL     in   fill value
//   BUS_REQ   out  bus request to the arbiter
//   BUS_GNT   in   bus grant (may drop in any cycle)
//   BUS_ADDR  out  bus address, 0 when BUS_WE=0
//   BUS_DATA  out  bus write data, 0 when BUS_WE=0
//   BUS_WE    out  write enable, one cycle per write
//   BUSY      out  high from the cycle after the accepted START through DONE
//   DONE      out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module vga_pixel_bus_writer #(
   parameter int          X_MAX     = 160,
   parameter int          Y_MAX     = 120,
   parameter logic [7:0]  ADDR_Y    = 8'hB0,
   parameter logic [7:0]  ADDR_X    = 8'hB1,
   parameter logic [7:0]  ADDR_DATA = 8'hB2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic [7:0] X0,
   input  logic [6:0] Y0,
   input  logic [7:0] WIDTH,
   input  logic [6:0] HEIGHT,
   input  logic       PIXEL,
   output logic       BUS_REQ,
   input  logic       BUS_GNT,
   output logic [7:0] BUS_ADDR,
   output logic [7:0] BUS_DATA,
   output logic       BUS_WE,
   output logic       BUSY,
   output logic       DONE
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CHECK  = 3'd1;
   localparam logic [2:0] S_REQ    = 3'd2;
   localparam logic [2:0] S_WR_Y   = 3'd3;
   localparam logic [2:0] S_WR_X   = 3'd4;
   localparam logic [2:0] S_WR_D   = 3'd5;
   localparam logic [2:0] S_FINISH = 3'd6;

   localparam logic [8:0] LP_X_MAX = 9'(X_MAX);
   localparam logic [7:0] LP_Y_MAX = 8'(Y_MAX);

   // Command state latched at START
   logic [2:0] r_state;
   logic [7:0] r_x;
   logic [6:0] r_y;
   logic [7:0] r_x0;
   logic [8:0] r_xe;
   logic [7:0] r_ye;
   logic       r_pix;

   // Registered outputs
   logic       r_req;
   logic       r_we;
   logic [7:0] r_addr;
   logic [7:0] r_data;
   logic       r_busy;
   logic       r_done;

   // The sums are one bit wider than the operands, so an origin near the edge
   // plus a large size cannot wrap back onto the screen.
   logic [8:0] w_x_sum;
   logic [7:0] w_y_sum;
   logic [8:0] w_xe;
   logic [7:0] w_ye;
   logic [8:0] w_x_inc;
   logic [7:0] w_y_inc;
   logic       w_empty;

   assign w_x_sum = {1'b0, X0} + {1'b0, WIDTH};
   assign w_y_sum = {1'b0, Y0} + {1'b0, HEIGHT};
   assign w_xe    = (w_x_sum > LP_X_MAX) ? LP_X_MAX : w_x_sum;
   assign w_ye    = (w_y_sum > LP_Y_MAX) ? LP_Y_MAX : w_y_sum;
   assign w_x_inc = {1'b0, r_x} + 9'd1;
   assign w_y_inc = {1'b0, r_y} + 8'd1;
   assign w_empty = ({1'b0, r_x} >= r_xe) || ({1'b0, r_y} >= r_ye);

   logic [2:0] w_state_nx;
   logic [7:0] w_x_nx;
   logic [6:0] w_y_nx;
   logic       w_is_wr_nx;
   logic       w_we_nx;
   logic [7:0] w_addr_nx;
   logic [7:0] w_data_nx;

   // r_we doubles as "the write of the current state was issued this cycle".
   // A write state advances only after its write has gone out. A stalled write
   // state (r_we=0) stays put until a grant is sampled.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      w_state_nx = r_state;
      w_x_nx     = r_x;
      w_y_nx     = r_y;
      case (r_state)
         S_IDLE:   if (START) w_state_nx = S_CHECK;
         S_CHECK:  w_state_nx = w_empty ? S_FINISH : S_REQ;
         S_REQ:    if (BUS_GNT) w_state_nx = S_WR_Y;
         S_WR_Y:   if (r_we) w_state_nx = S_WR_X;
         S_WR_X:   if (r_we) w_state_nx = S_WR_D;
         S_WR_D: begin
            if (r_we) begin
               if (w_x_inc < r_xe) begin
                  w_x_nx     = w_x_inc[7:0];
                  w_state_nx = S_WR_X;
               end else if (w_y_inc < r_ye) begin
                  w_x_nx     = r_x0;
                  w_y_nx     = w_y_inc[6:0];
                  w_state_nx = S_WR_Y;
               end else begin
                  w_state_nx = S_FINISH;
               end
            end
         end
         S_FINISH: w_state_nx = S_IDLE;
         default:  w_state_nx = S_IDLE;
      endcase

      w_is_wr_nx = (w_state_nx == S_WR_Y) || (w_state_nx == S_WR_X) ||
                   (w_state_nx == S_WR_D);
      w_we_nx    = w_is_wr_nx && BUS_GNT;

      w_addr_nx = 8'h00;
      w_data_nx = 8'h00;
      if (w_we_nx) begin
         case (w_state_nx)
            S_WR_Y: begin
               w_addr_nx = ADDR_Y;
               w_data_nx = {1'b0, w_y_nx};
            end
            S_WR_X: begin
               w_addr_nx = ADDR_X;
               w_data_nx = w_x_nx;
            end
            default: begin
               w_addr_nx = ADDR_DATA;
               w_data_nx = {7'b0, r_pix};
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= S_IDLE;
         r_x     <= 8'h00;
         r_y     <= 7'h00;
         r_x0    <= 8'h00;
         r_xe    <= 9'h000;
         r_ye    <= 8'h00;
         r_pix   <= 1'b0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= 8'h00;
         r_data  <= 8'h00;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_state <= w_state_nx;
         r_req   <= w_is_wr_nx || (w_state_nx == S_REQ);
         r_we    <= w_we_nx;
         r_addr  <= w_addr_nx;
         r_data  <= w_data_nx;
         r_busy  <= (w_state_nx != S_IDLE);
         r_done  <= (w_state_nx == S_FINISH);
         if (r_state == S_IDLE && START) begin
            // Command is frozen here. Later input changes have no effect.
            r_x   <= X0;
            r_y   <= Y0;
            r_x0  <= X0;
            r_xe  <= w_xe;
            r_ye  <= w_ye;
            r_pix <= PIXEL;
         end else begin
            r_x <= w_x_nx;
            r_y <= w_y_nx;
         end
      end
   end

   assign BUS_REQ  = r_req;
   assign BUS_WE   = r_we;
   assign BUS_ADDR = r_addr;
   assign BUS_DATA = r_data;
   assign BUSY     = r_busy;
   assign DONE     = r_done;

endmodule

// File: tb/tb_vga_pixel_bus_writer.sv
// -----------------------------------------------------------------------------
// tb_vga_pixel_bus_writer
//
// Directed and randomized fills of vga_pixel_bus_writer. Expected bus writes
// are queued when a command is issued. A negedge monitor pops and compares
// each write that appears on the bus.
// -----------------------------------------------------------------------------
module tb_vga_pixel_bus_writer;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       START;
   logic [7:0] X0;
   logic [6:0] Y0;
   logic [7:0] WIDTH;
   logic [6:0] HEIGHT;
   logic       PIXEL;
   logic       BUS_REQ;
   logic       BUS_GNT;
   logic [7:0] BUS_ADDR;
   logic [7:0] BUS_DATA;
   logic       BUS_WE;
   logic       BUSY;
   logic       DONE;

   vga_pixel_bus_writer dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .START    (START),
      .X0       (X0),
      .Y0       (Y0),
      .WIDTH    (WIDTH),
      .HEIGHT   (HEIGHT),
      .PIXEL    (PIXEL),
      .BUS_REQ  (BUS_REQ),
      .BUS_GNT  (BUS_GNT),
      .BUS_ADDR (BUS_ADDR),
      .BUS_DATA (BUS_DATA),
      .BUS_WE   (BUS_WE),
      .BUSY     (BUSY),
      .DONE     (DONE)
   );

   always #5 CLK = ~CLK;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] sb[$];
   logic [15:0] exp_wr;
   int          cyc = 0;
   int          wr_cnt;
   int          done_cnt;
   int          first_we;
   int          last_we;
   int          done_cyc;
   bit          req_seen;
   bit          we_seen;
   bit          rnd_gnt = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Bus monitor and scoreboard
   always @(negedge CLK) begin
      cyc++;
      if (BUS_REQ) req_seen = 1'b1;
      if (DONE) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (BUS_WE) begin
         we_seen = 1'b1;
         wr_cnt++;
         if (first_we < 0) first_we = cyc;
         last_we = cyc;
         check("write_expected", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            exp_wr = sb.pop_front();
            check("write", {BUS_ADDR, BUS_DATA}, exp_wr);
         end
      end else begin
         check("idle_bus_zero", {BUS_ADDR, BUS_DATA}, 16'h0000);
      end
   end

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   task automatic clear_stats();
      wr_cnt   = 0;
      done_cnt = 0;
      first_we = -1;
      last_we  = -1;
      done_cyc = -1;
      req_seen = 1'b0;
      we_seen  = 1'b0;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] d);
      sb.push_back({a, d});
   endtask

   // Reference model: clipped rectangle, row by row
   task automatic push_rect(input int x0, input int y0, input int w, input int h, input bit pix);
      int xe;
      int ye;
      xe = (x0 + w > 160) ? 160 : x0 + w;
      ye = (y0 + h > 120) ? 120 : y0 + h;
      if (x0 < xe && y0 < ye) begin
         for (int y = y0; y < ye; y++) begin
            push(8'hB0, 8'(y));
            for (int x = x0; x < xe; x++) begin
               push(8'hB1, 8'(x));
               push(8'hB2, {7'b0, pix});
            end
         end
      end
   endtask

   task automatic issue(input int x0, input int y0, input int w, input int h, input bit pix);
      X0     = 8'(x0);
      Y0     = 7'(y0);
      WIDTH  = 8'(w);
      HEIGHT = 7'(h);
      PIXEL  = pix;
      START  = 1'b1;
      step();
      START  = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 600; i++) begin
         if (done_cnt > 0) break;
         if (rnd_gnt) BUS_GNT = ($urandom_range(0, 3) != 0);
         step();
      end
      BUS_GNT = 1'b1;
      check({tag, "_done_seen"}, (done_cnt > 0), 1);
   endtask

   task automatic wait_writes(input string tag, input int n);
      for (int i = 0; i < 100; i++) begin
         if (wr_cnt >= n) break;
         step();
      end
      check({tag, "_write_count"}, wr_cnt, n);
   endtask

   initial begin
      RESET   = 1'b0;
      START   = 1'b0;
      BUS_GNT = 1'b1;
      X0      = 8'h00;
      Y0      = 7'h00;
      WIDTH   = 8'h00;
      HEIGHT  = 7'h00;
      PIXEL   = 1'b0;
      clear_stats();
      repeat (3) step();
      check("reset_outputs", {BUS_REQ, BUS_WE, BUSY, DONE, BUS_ADDR, BUS_DATA}, 0);
      RESET = 1'b1;
      step();

      // Basic fill
      clear_stats();
      push(8'hB0, 8'h03); push(8'hB1, 8'h05); push(8'hB2, 8'h01);
      push(8'hB1, 8'h06); push(8'hB2, 8'h01);
      issue(5, 3, 2, 1, 1'b1);
      check("basic_busy", BUSY, 1);
      wait_done("basic");
      check("basic_writes", wr_cnt, 5);
      check("basic_consecutive", last_we - first_we + 1, 5);
      check("basic_done_after_last", done_cyc, last_we + 1);
      check("basic_sb_empty", sb.size(), 0);
      step();
      check("basic_busy_fall", {BUSY, DONE}, 2'b00);
      check("basic_done_once", done_cnt, 1);

      // Multi-row
      clear_stats();
      for (int r = 0; r < 3; r++) begin
         push(8'hB0, 8'(r)); push(8'hB1, 8'h00); push(8'hB2, 8'h00);
      end
      issue(0, 0, 1, 3, 1'b0);
      wait_done("multirow");
      check("multirow_writes", wr_cnt, 9);
      check("multirow_consecutive", last_we - first_we + 1, 9);
      check("multirow_sb_empty", sb.size(), 0);
      step();

      // Clipping at the right and bottom edges
      clear_stats();
      push(8'hB0, 8'h77); push(8'hB1, 8'h9E); push(8'hB2, 8'h01);
      push(8'hB1, 8'h9F); push(8'hB2, 8'h01);
      issue(158, 119, 4, 2, 1'b1);
      wait_done("clip");
      check("clip_writes", wr_cnt, 5);
      check("clip_sb_empty", sb.size(), 0);
      step();

      // Empty (WIDTH=0) and fully offscreen origin
      clear_stats();
      issue(10, 10, 0, 5, 1'b1);
      check("w0_check_state", {BUSY, DONE}, 2'b10);
      step();
      check("w0_done_2cyc", {BUSY, DONE}, 2'b11);
      step();
      check("w0_idle", {BUSY, DONE}, 2'b00);
      check("w0_no_bus", {req_seen, we_seen}, 2'b00);

      clear_stats();
      issue(200, 10, 10, 5, 1'b1);
      step();
      check("offscreen_done_2cyc", {BUSY, DONE}, 2'b11);
      step();
      check("offscreen_no_bus", {req_seen, we_seen}, 2'b00);

      // START while busy is ignored
      clear_stats();
      push_rect(5, 3, 2, 1, 1'b1);
      issue(5, 3, 2, 1, 1'b1);
      step();
      issue(0, 0, 3, 3, 1'b0);
      wait_done("busy_start");
      repeat (20) step();
      check("busy_start_one_done", done_cnt, 1);
      check("busy_start_writes", wr_cnt, 5);
      check("busy_start_sb_empty", sb.size(), 0);

      // Grant stall between the X write and the data write
      clear_stats();
      push(8'hB0, 8'h03); push(8'hB1, 8'h05); push(8'hB2, 8'h01);
      push(8'hB1, 8'h06); push(8'hB2, 8'h01);
      issue(5, 3, 2, 1, 1'b1);
      wait_writes("stall_pre", 2);
      BUS_GNT = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_we_low", BUS_WE, 0);
         check("stall_req_high", BUS_REQ, 1);
      end
      BUS_GNT = 1'b1;
      wait_done("stall");
      check("stall_writes", wr_cnt, 5);
      check("stall_sb_empty", sb.size(), 0);
      step();

      // Reset in the middle of a 4x4 fill
      clear_stats();
      push_rect(10, 20, 4, 4, 1'b1);
      issue(10, 20, 4, 4, 1'b1);
      wait_writes("rst_pre", 2);
      RESET = 1'b0;
      #1;
      check("rst_outputs_zero", {BUS_REQ, BUS_WE, BUSY, DONE, BUS_ADDR, BUS_DATA}, 0);
      sb.delete();
      step();
      step();
      check("rst_held_zero", {BUS_REQ, BUS_WE, BUSY, DONE, BUS_ADDR, BUS_DATA}, 0);
      check("rst_no_done", done_cnt, 0);
      check("rst_writes_stopped", wr_cnt, 2);
      RESET = 1'b1;
      step();
      clear_stats();
      push(8'hB0, 8'h02); push(8'hB1, 8'h01); push(8'hB2, 8'h00);
      issue(1, 2, 1, 1, 1'b0);
      wait_done("rst_restart");
      check("rst_restart_writes", wr_cnt, 3);
      check("rst_restart_sb_empty", sb.size(), 0);
      step();

      // Randomized rectangles with a randomly toggling grant
      rnd_gnt = 1'b1;
      for (int t = 0; t < 6; t++) begin
         int x0;
         int y0;
         int w;
         int h;
         int xe;
         int ye;
         int nw;
         x0 = $urandom_range(0, 170);
         y0 = $urandom_range(0, 125);
         w  = $urandom_range(0, 12);
         h  = $urandom_range(0, 5);
         xe = (x0 + w > 160) ? 160 : x0 + w;
         ye = (y0 + h > 120) ? 120 : y0 + h;
         nw = (x0 < xe && y0 < ye) ? (ye - y0) + 2 * (xe - x0) * (ye - y0) : 0;
         clear_stats();
         push_rect(x0, y0, w, h, t[0]);
         issue(x0, y0, w, h, t[0]);
         wait_done("rand");
         check("rand_writes", wr_cnt, nw);
         check("rand_sb_empty", sb.size(), 0);
         step();
         check("rand_idle", BUSY, 0);
      end
      rnd_gnt = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_pixel_bus_writer.md
Name: vga_pixel_bus_writer

Overview:
- Bus initiator that fills a rectangle of the 160x120 monochrome frame buffer by issuing byte writes to the VGA peripheral's register map.
- Register map: 0xB0 = Y row, 0xB1 = X column, 0xB2 = pixel data (bit 0).
- Sits between a command source (e.g. a microcontroller peripheral or a test pattern FSM) and the shared ADDRESS/DATA/WE bus.
- Requests the bus, clips the rectangle to the screen, and streams writes. Each row costs one Y write; each pixel costs an X write followed by a data write.

Parameters:
- X_MAX, 160, screen width in pixels; columns >= X_MAX are clipped.
- Y_MAX, 120, screen height in pixels; rows >= Y_MAX are clipped.
- ADDR_Y, 8'hB0, bus address of the row register.
- ADDR_X, 8'hB1, bus address of the column register.
- ADDR_DATA, 8'hB2, bus address of the pixel data register.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- START  in  1  one-cycle command strobe; sampled only in IDLE
- X0  in  8  rectangle left column
- Y0  in  7  rectangle top row
- WIDTH  in  8  columns, 0..255
- HEIGHT  in  7  rows, 0..127
- PIXEL  in  1  fill value
- BUS_REQ  out  1  bus request to arbiter
- BUS_GNT  in  1  bus grant; may drop at any cycle
- BUS_ADDR  out  8  bus address
- BUS_DATA  out  8  bus write data
- BUS_WE  out  1  bus write enable, one cycle per write
- BUSY  out  1  high from cycle after accepted START until DONE cycle inclusive
- DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, RESET=0): state IDLE; BUS_REQ, BUS_ADDR, BUS_DATA, BUS_WE, BUSY and DONE are all 0. Abort mid-operation with no DONE and no further writes. Operation resumes on the first edge after RESET=1.
- All outputs are registered. BUS_ADDR and BUS_DATA are 0 whenever BUS_WE=0.
- On START in IDLE, latch the command and compute clipped bounds using 9-bit arithmetic (no wrap):
  - xe = min(X0+WIDTH, X_MAX)
  - ye = min(Y0+HEIGHT, Y_MAX)
- The rectangle is empty if X0 >= xe or Y0 >= ye, which covers WIDTH=0, HEIGHT=0 and a fully offscreen origin.
- START while BUSY is ignored. PIXEL and bounds are frozen at latch time.
- States: IDLE, CHECK, REQ, WR_Y, WR_X, WR_D, FINISH.
  - IDLE: START -> CHECK.
  - CHECK: BUSY=1. Empty -> FINISH with no bus activity. Otherwise -> REQ with x=X0, y=Y0.
  - REQ: BUS_REQ=1. On BUS_GNT=1 sampled -> WR_Y.
  - WR_Y: BUS_WE=1, ADDR_Y, DATA={1'b0,y}.
  - WR_X: BUS_WE=1, ADDR_X, DATA=x.
  - WR_D: BUS_WE=1, ADDR_DATA, DATA={7'b0,PIXEL}.
  - After WR_D:
    - If x+1 < xe: x++ -> WR_X.
    - Else if y+1 < ye: x=X0, y++ -> WR_Y.
    - Else -> FINISH.
  - FINISH: DONE=1, BUSY=1, BUS_REQ=0 -> IDLE.
- BUS_REQ stays 1 from REQ through the last WR_D.
- Arbitration rule: a write state issues a write (WE=1) only in a cycle where BUS_GNT was 1 at the previous edge.
  - If GNT is 0, hold the state with WE=0, BUS_REQ=1, and no skipped or duplicated write.
  - This rule includes GNT dropping between WR_X and WR_D. WR_D then resumes without repeating WR_X, because the peripheral keeps its X register.
- Write count for a clipped rectangle of w x h pixels: h + 2*w*h. With GNT held at 1, REQ->FINISH takes exactly h + 2*w*h + 1 cycles after REQ's grant edge.

Test Plan:
- Basic fill: X0=5, Y0=3, W=2, H=1, PIXEL=1, GNT=1.
  - Required writes: (B0,03) (B1,05) (B2,01) (B1,06) (B2,01) on consecutive cycles.
  - Then DONE pulses once and BUSY falls the following cycle.
- Multi-row: X0=0, Y0=0, W=1, H=3, PIXEL=0.
  - Required writes: (B0,00)(B1,00)(B2,00)(B0,01)(B1,00)(B2,00)(B0,02)(B1,00)(B2,00), 9 writes total.
- Clipping: X0=158, W=4, Y0=119, H=2.
  - Required writes: only (B0,77)(B1,9E)(B2,p)(B1,9F)(B2,p).
  - No write of Y=0x78 and no X >= 0xA0.
- Empty and offscreen:
  - WIDTH=0: DONE asserts 2 cycles after START, with BUS_REQ and BUS_WE never 1.
  - X0=200, W=10: same response.
  - A START asserted during BUSY produces no second DONE.
- Grant stall: same command as the basic fill, with GNT forced to 0 for 3 cycles right after the first (B1,05) write.
  - WE must be 0 for those 3 cycles.
  - Then (B2,01) (B1,06) (B2,01) follow, giving exactly 5 writes total.
- Reset mid-operation: assert RESET=0 after the 2nd write of a 4x4 fill.
  - All outputs must be 0 immediately, with no DONE.
  - A new START after release restarts cleanly from (B0,Y0).
